rtc_bus_sequencer: RTL and testbench
====================================

Name: rtc_bus_sequencer

Overview:
Parametrised transaction engine for the multiplexed address/data bus of the external RTC. It generates the chip-select, read, write and address/data (AoD) strobes with configurable phase timing, and drives and captures the bus byte. It has a start/busy/done handshake toward the RTC controller FSM. It replaces free-running strobe generation with one complete, single-shot read or write per request.

Parameters:
DATA_W, 8, width of the bus, address and data bytes
T_SETUP, 2, clk cycles of bus setup before each strobe (>=1)
T_STROBE, 3, clk cycles each RD/WR strobe is held low (>=1)
T_HOLD, 1, clk cycles of bus hold after each strobe (>=1)
T_GAP, 2, clk cycles with chip-select high after a transaction (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request pulse or level; sampled only in IDLE
rw  in  1  1 = read, 0 = write; latched with start
addr  in  DATA_W  RTC register address; latched with start
wdata  in  DATA_W  write byte; latched with start
busy  out  1  high from the cycle after acceptance until return to IDLE
done  out  1  one-cycle pulse at transaction end
rdata  out  DATA_W  captured read byte; held until the next read completes
rdata_valid  out  1  one-cycle pulse with done, only on reads
cs_n  out  1  chip select, active low
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
ad_n  out  1  0 = address phase, 1 = data phase
bus_out  out  DATA_W  value driven onto the bus
bus_oe  out  1  tri-state enable for bus_out (the tri-state buffer is at top level)
bus_in  in  DATA_W  bus sampled value

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - cs_n=rd_n=wr_n=ad_n=1
  - bus_oe=0, bus_out=0
  - busy=done=rdata_valid=0, rdata=0
  - FSM returns to IDLE.
- Clocking: all outputs are registered. A single down-counter loads phase length minus 1 on each state entry.
- States and sequence:
  - IDLE -> ADDR_SETUP -> ADDR_STROBE -> ADDR_HOLD -> DATA_SETUP -> DATA_STROBE -> DATA_HOLD -> RECOVER -> IDLE.
- IDLE:
  - start=1 at edge N latches rw/addr/wdata.
  - At N+1: busy=1, cs_n=0, ad_n=0, bus_oe=1, bus_out=addr.
- ADDR_SETUP: T_SETUP cycles.
- ADDR_STROBE: wr_n=0 for T_STROBE cycles, for both reads and writes (address latch).
- ADDR_HOLD: wr_n=1; address still driven; T_HOLD cycles.
- DATA_SETUP: ad_n=1; T_SETUP cycles.
  - Write: bus_out=wdata, bus_oe=1.
  - Read: bus_oe=0.
- DATA_STROBE: T_STROBE cycles.
  - Write: wr_n=0.
  - Read: rd_n=0; bus_in is captured into rdata on the final strobe cycle, before rd_n rises.
- DATA_HOLD: strobes high; a write keeps driving the bus; T_HOLD cycles.
- RECOVER: T_GAP cycles.
  - cs_n=1, ad_n=1, bus_oe=0.
  - done=1 (and rdata_valid=1 on a read) on the first RECOVER cycle only.
  - busy stays 1; busy=0 on return to IDLE.
- Busy length: 2*(T_SETUP+T_STROBE+T_HOLD)+T_GAP cycles (14 at defaults).
- start while busy: ignored, not queued.
- start held high continuously: the next transaction is accepted in the IDLE cycle, so busy=0 for exactly 1 cycle.
- rd_n and wr_n are never low simultaneously. cs_n is low whenever either is low.
- The counter width is derived from the largest parameter. Parameter values of 0 are illegal; the block rejects them with a $error at elaboration.

Optional Feature:
- Macro: RTC_ADDR_SKIP_EN
- Defined:
  - The block keeps last_addr and a valid flag, set at end of each completed transaction.
  - A new request with addr==last_addr and valid=1 goes IDLE -> DATA_SETUP directly: cs_n=0, ad_n=1, with no address phase.
  - Busy is 8 cycles at defaults.
  - Reset clears valid.
- Not defined: every transaction runs the full address phase. There is no last_addr storage.

Test Plan:
1. Write at defaults, rw=0, addr=0x21, wdata=0x5A:
   - wr_n low 3 cycles with bus_out=0x21, ad_n=0.
   - Then wr_n low 3 cycles with bus_out=0x5A, ad_n=1.
   - busy high 14 cycles; done pulse at busy cycle 13; rd_n stays 1.
2. Read, rw=1, addr=0x23, bus model drives 0xC3 while rd_n=0:
   - bus_oe=0 in the data phase.
   - rdata=0xC3 with a 1-cycle rdata_valid coincident with done; wr_n low only in the address phase.
3. start pulsed at busy cycles 3 and 10 of a transaction:
   - Both are ignored; exactly one done.
   - start held high for two transactions gives busy low for exactly 1 cycle between them.
4. reset asserted during DATA_STROBE of a write:
   - Same cycle, asynchronously: cs_n=wr_n=1, bus_oe=0, busy=0, with no done.
   - After release, a new write completes normally.
5. Parameters T_SETUP=1, T_STROBE=1, T_HOLD=1, T_GAP=1: busy is 7 cycles; strobe widths are 1 cycle.
6. With RTC_ADDR_SKIP_EN, two reads of 0x24:
   - First read: 14 busy cycles. Second read: 8 busy cycles with no address strobe.
   - After a reset, a third read of 0x24 takes 14 cycles again.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Single-shot read/write sequencer for the RTC multiplexed address/data bus; optional RTC_ADDR_SKIP_EN omits the address phase on a repeated address.
// Latency: outputs registered, busy 2*(T_SETUP+T_STROBE+T_HOLD)+T_GAP cycles (T_SETUP+T_STROBE+T_HOLD+T_GAP when skipped).
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
module rtc_bus_sequencer #(
  parameter int DATA_W   = 8,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 3,
  parameter int T_HOLD   = 1,
  parameter int T_GAP    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              ad_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in
);

  localparam int MAX_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  if (DATA_W < 1 || T_SETUP < 1 || T_STROBE < 1 || T_HOLD < 1 || T_GAP < 1) begin : g_bad_param
    $error("rtc_bus_sequencer: DATA_W and all timing parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD, RECOVER
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              rw_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              skip;
  logic              src_rw;
  logic [DATA_W-1:0] src_addr, src_wdata, bus_out_nxt;
  logic              busy_nxt, done_nxt, rv_nxt, cs_nxt, rd_nxt, wr_nxt, ad_nxt, oe_nxt;

  function automatic logic [CW-1:0] phase_len(input state_t s);
    case (s)
      ADDR_SETUP, DATA_SETUP:   return CW'(T_SETUP - 1);
      ADDR_STROBE, DATA_STROBE: return CW'(T_STROBE - 1);
      ADDR_HOLD, DATA_HOLD:     return CW'(T_HOLD - 1);
      RECOVER:                  return CW'(T_GAP - 1);
      default:                  return '0;
    endcase
  endfunction

  // Outputs are computed from the next state, so on acceptance the request
  // fields come straight from the inputs rather than the latched copies.
  assign src_rw    = (state == IDLE) ? rw    : rw_q;
  assign src_addr  = (state == IDLE) ? addr  : addr_q;
  assign src_wdata = (state == IDLE) ? wdata : wdata_q;

`ifdef RTC_ADDR_SKIP_EN
  logic [DATA_W-1:0] last_addr;
  logic              last_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_addr <= '0;
      last_vld  <= 1'b0;
    end else if (state != RECOVER && state_nxt == RECOVER) begin
      last_addr <= addr_q;
      last_vld  <= 1'b1;
    end
  end

  assign skip = last_vld && (addr == last_addr);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start) state_nxt = skip ? DATA_SETUP : ADDR_SETUP;
      ADDR_SETUP:  if (cnt == '0) state_nxt = ADDR_STROBE;
      ADDR_STROBE: if (cnt == '0) state_nxt = ADDR_HOLD;
      ADDR_HOLD:   if (cnt == '0) state_nxt = DATA_SETUP;
      DATA_SETUP:  if (cnt == '0) state_nxt = DATA_STROBE;
      DATA_STROBE: if (cnt == '0) state_nxt = DATA_HOLD;
      DATA_HOLD:   if (cnt == '0) state_nxt = RECOVER;
      RECOVER:     if (cnt == '0) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase

    cnt_nxt = cnt;
    if (state_nxt != state)  cnt_nxt = phase_len(state_nxt);
    else if (cnt != '0)      cnt_nxt = cnt - CW'(1);

    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = 1'b0;
    rv_nxt      = 1'b0;
    cs_nxt      = 1'b1;
    rd_nxt      = 1'b1;
    wr_nxt      = 1'b1;
    ad_nxt      = 1'b1;
    oe_nxt      = 1'b0;
    bus_out_nxt = bus_out;
    case (state_nxt)
      ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
        cs_nxt      = 1'b0;
        ad_nxt      = 1'b0;
        oe_nxt      = 1'b1;
        bus_out_nxt = src_addr;
        wr_nxt      = (state_nxt != ADDR_STROBE);
      end
      DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
        cs_nxt = 1'b0;
        oe_nxt = !src_rw;
        if (!src_rw) bus_out_nxt = src_wdata;
        if (state_nxt == DATA_STROBE) begin
          rd_nxt = !src_rw;
          wr_nxt = src_rw;
        end
      end
      RECOVER: begin
        done_nxt = (state != RECOVER);
        rv_nxt   = (state != RECOVER) && src_rw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      cs_n        <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      ad_n        <= 1'b1;
      bus_oe      <= 1'b0;
      bus_out     <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      rdata_valid <= rv_nxt;
      cs_n        <= cs_nxt;
      rd_n        <= rd_nxt;
      wr_n        <= wr_nxt;
      ad_n        <= ad_nxt;
      bus_oe      <= oe_nxt;
      bus_out     <= bus_out_nxt;
      if (state == IDLE && start) begin
        rw_q    <= rw;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      // Sample on the last low cycle of rd_n, before the strobe rises.
      if (state == DATA_STROBE && cnt == '0 && rw_q) rdata <= bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: default-timing instance plus a minimum-timing instance.
module tb_rtc_bus_sequencer;

  localparam int TS = 2, TST = 3, TH = 1, TG = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, rw;
  logic [7:0] addr, wdata, rd_val, bus_in, rdata, bus_out;
  logic       busy, done, rdata_valid, cs_n, rd_n, wr_n, ad_n, bus_oe;

  logic       f_start, f_rw;
  logic [7:0] f_addr, f_wdata, f_bus_in, f_rdata, f_bus_out;
  logic       f_busy, f_done, f_rdata_valid, f_cs_n, f_rd_n, f_wr_n, f_ad_n, f_bus_oe;

  always #5 clk = ~clk;

  assign bus_in   = !rd_n   ? rd_val : 8'hEE;
  assign f_bus_in = !f_rd_n ? 8'h96  : 8'hEE;

  rtc_bus_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .rdata_valid(rdata_valid),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );

  rtc_bus_sequencer #(.DATA_W(8), .T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1)) u_fast (
    .clk(clk), .reset(reset), .start(f_start), .rw(f_rw), .addr(f_addr), .wdata(f_wdata),
    .busy(f_busy), .done(f_done), .rdata(f_rdata), .rdata_valid(f_rdata_valid),
    .cs_n(f_cs_n), .rd_n(f_rd_n), .wr_n(f_wr_n), .ad_n(f_ad_n),
    .bus_out(f_bus_out), .bus_oe(f_bus_oe), .bus_in(f_bus_in)
  );

  typedef struct {
    logic       rw;
    logic [7:0] addr, wdata, rdata;
    int         aw, dw, rd, oe, done_at, busy_len;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_chk = 0, n_fail = 0;

  logic [7:0] m_rdata, m_last;
  logic       m_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected results are derived from the request and the timing formula.
  task automatic issue(input logic r, input logic [7:0] a, input logic [7:0] w, input logic [7:0] v);
    exp_t e;
    logic sk;
    sk = 1'b0;
`ifdef RTC_ADDR_SKIP_EN
    sk = m_vld && (m_last == a);
`endif
    m_vld  = 1'b1;
    m_last = a;
    if (r) m_rdata = v;
    e.rw       = r;
    e.addr     = a;
    e.wdata    = w;
    e.rdata    = m_rdata;
    e.aw       = sk ? 0 : TST;
    e.dw       = r ? 0 : TST;
    e.rd       = r ? TST : 0;
    e.oe       = r ? 0 : TS + TST + TH;
    e.busy_len = sk ? TS + TST + TH + TG : 2 * (TS + TST + TH) + TG;
    e.done_at  = e.busy_len - TG + 1;
    sb.push_back(e);
    rw = r; addr = a; wdata = w; rd_val = v; start = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    for (int t = 0; t < 100 && busy !== lvl; t++) @(negedge clk);
    check(tag, busy, lvl);
  endtask

  task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] w, input logic [7:0] v);
    issue(r, a, w, v);
    @(negedge clk);
    start = 1'b0;
    wait_busy(1'b0, "busy_drop");
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    m_vld = 1'b0;
    m_rdata = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic fast_txn(input logic r, input logic [7:0] a, input logic [7:0] w);
    int fb, faw, fdw, frd, fd;
    fb = 0; faw = 0; fdw = 0; frd = 0; fd = 0;
    f_rw = r; f_addr = a; f_wdata = w; f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (f_busy) fb++;
      if (!f_wr_n && !f_ad_n) faw++;
      if (!f_wr_n && f_ad_n) fdw++;
      if (!f_rd_n) frd++;
      if (f_done) fd++;
      if (!f_busy && fb > 0) break;
      @(negedge clk);
    end
    check("fast_busy_len", fb, 7);
    check("fast_addr_strobe", faw, 1);
    check("fast_data_wr", fdw, r ? 0 : 1);
    check("fast_data_rd", frd, r ? 1 : 0);
    check("fast_done_cnt", fd, 1);
    if (r) check("fast_rdata", f_rdata, 8'h96);
  endtask

  int         busy_cnt, aw_cnt, dw_cnt, rd_cnt, oe_cnt, n_done, idle_run, last_gap;
  logic [7:0] a_seen, d_seen;
  logic       busy_q;

  initial begin
    busy_cnt = 0; aw_cnt = 0; dw_cnt = 0; rd_cnt = 0; oe_cnt = 0;
    n_done = 0; idle_run = 0; last_gap = 0; busy_q = 1'b0;
    a_seen = 8'h00; d_seen = 8'h00;
  end

  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      busy_cnt = 0; aw_cnt = 0; dw_cnt = 0; rd_cnt = 0; oe_cnt = 0;
      busy_q = 1'b0;
    end else begin
      check("strobe_excl", !rd_n && !wr_n, 1'b0);
      check("cs_covers_strobe", (!rd_n || !wr_n) && cs_n, 1'b0);
      check("rv_only_with_done", rdata_valid && !done, 1'b0);
      if (busy) busy_cnt++;
      if (!wr_n && !ad_n) begin aw_cnt++; a_seen = bus_out; end
      if (!wr_n && ad_n) begin dw_cnt++; d_seen = bus_out; end
      if (!rd_n) rd_cnt++;
      if (!cs_n && ad_n && bus_oe) oe_cnt++;
      if (done) begin
        n_done++;
        check("done_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("done_at", busy_cnt, cur.done_at);
          check("addr_strobe_len", aw_cnt, cur.aw);
          check("data_wr_len", dw_cnt, cur.dw);
          check("data_rd_len", rd_cnt, cur.rd);
          check("data_oe_cycles", oe_cnt, cur.oe);
          if (cur.aw > 0) check("addr_on_bus", a_seen, cur.addr);
          if (!cur.rw) check("wdata_on_bus", d_seen, cur.wdata);
          check("rdata_valid", rdata_valid, cur.rw);
          check("rdata", rdata, cur.rdata);
        end
      end
      if (busy_q && !busy) begin
        check("busy_len", busy_cnt, cur.busy_len);
        busy_cnt = 0; aw_cnt = 0; dw_cnt = 0; rd_cnt = 0; oe_cnt = 0;
        idle_run = 0;
      end
      if (!busy_q && busy) last_gap = idle_run;
      if (!busy) idle_run++;
      busy_q = busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b0; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00; rd_val = 8'h00;
    f_start = 1'b0; f_rw = 1'b0; f_addr = 8'h00; f_wdata = 8'h00;
    m_vld = 1'b0; m_last = 8'h00; m_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_rd_n", rd_n, 1'b1);
    check("rst_wr_n", wr_n, 1'b1);
    check("rst_ad_n", ad_n, 1'b1);
    check("rst_bus_oe", bus_oe, 1'b0);
    check("rst_bus_out", bus_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 8'h21, 8'h5A, 8'h00);
    run_txn(1'b1, 8'h23, 8'h00, 8'hC3);
    run_txn(1'b0, 8'h40, 8'hA5, 8'h00);
    run_txn(1'b1, 8'h41, 8'h00, 8'h3C);

    // start pulses during busy cycles 3 and 10 must be dropped
    d0 = n_done;
    issue(1'b0, 8'h50, 8'h77, 8'h00);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 10);
    end
    start = 1'b0;
    wait_busy(1'b0, "pulse_busy_drop");
    repeat (3) @(negedge clk);
    check("ignored_start_idle", busy, 1'b0);
    check("ignored_start_one_done", n_done - d0, 1);

    // start held high across two transactions
    issue(1'b0, 8'h30, 8'h11, 8'h00);
    @(negedge clk);
    issue(1'b0, 8'h31, 8'h22, 8'h00);
    wait_busy(1'b0, "held_first_end");
    wait_busy(1'b1, "held_second_start");
    start = 1'b0;
    wait_busy(1'b0, "held_second_end");
    check("held_gap_len", last_gap, 1);
    @(negedge clk);

    // asynchronous reset during the write data strobe
    d0 = n_done;
    issue(1'b0, 8'h60, 8'h99, 8'h00);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 40 && !(!wr_n && ad_n); t++) @(negedge clk);
    check("reached_data_strobe", !wr_n && ad_n, 1'b1);
    #2 reset = 1'b0;
    m_vld = 1'b0;
    m_rdata = 8'h00;
    #1;
    check("arst_cs_n", cs_n, 1'b1);
    check("arst_wr_n", wr_n, 1'b1);
    check("arst_bus_oe", bus_oe, 1'b0);
    check("arst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("arst_no_done", n_done - d0, 0);
    reset = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 8'h61, 8'h42, 8'h00);

    fast_txn(1'b0, 8'h10, 8'hB4);
    @(negedge clk);
    fast_txn(1'b1, 8'h11, 8'h00);
    @(negedge clk);

    // repeated address: shortened only when the skip feature is built in
    run_txn(1'b1, 8'h24, 8'h00, 8'h5D);
    run_txn(1'b1, 8'h24, 8'h00, 8'h6E);
    pulse_reset();
    run_txn(1'b1, 8'h24, 8'h00, 8'h7F);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
